// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
// Builds a byte-lane data-memory request with a req/ack handshake, holds the
// upstream pipeline while memory is busy, aligns/extends load data and owns
// the MEM/WB register.
// Optional feature: MEM_MISALIGN_TRAP_EN (adds Misalign_wb, traps misaligned
// half/word accesses instead of forcing them onto the aligned lane).
module mem_stage #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic        MemToReg_mem,
  input  logic        RegWrite_mem,
  input  logic [1:0]  MemSize_mem,
  input  logic        MemSigned_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] StoreData_mem,
  output logic        Stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        Misalign_wb,
`endif
  output logic        MemToReg_wb,
  output logic        RegWrite_wb,
  output logic [4:0]  WriteReg_wb,
  output logic [31:0] MemDout_wb,
  output logic [31:0] ALUResult_wb,
  output logic        BusErr_wb
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // Counter wide enough to hold TIMEOUT_CYC (at least 1 bit when disabled)
  localparam int            CW     = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYC);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        MemToReg_q, RegWrite_q, BusErr_q;
  logic [4:0]  WriteReg_q;
  logic [31:0] MemDout_q, ALUResult_q;

  logic        op, misal, req, stall, bus_err, done, take, to_hit;
  logic        is_byte, is_half, is_word;
  logic [1:0]  lane, eff_lane;
  logic [31:0] sh, ld;

  assign op      = MemRead_mem | MemWrite_mem;
  assign lane    = ALUResult_mem[1:0];
  assign is_byte = (MemSize_mem == 2'b00);
  assign is_half = (MemSize_mem == 2'b01);
  assign is_word = MemSize_mem[1];

  // Misaligned half/word accesses are snapped onto their aligned lane
  assign eff_lane = is_half ? {lane[1], 1'b0} : (is_word ? 2'b00 : lane);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = op & ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_VAL);

  // Request formatting: upstream is held during the access, so these stay stable
  always_comb begin
    dmem_addr  = {ALUResult_mem[31:2], 2'b00};
    dmem_we    = MemWrite_mem;
    dmem_be    = 4'b1111;
    dmem_wdata = StoreData_mem;
    if (is_byte) begin
      dmem_wdata = {4{StoreData_mem[7:0]}};
      if (!MemRead_mem) dmem_be = 4'b0001 << eff_lane;
    end else if (is_half) begin
      dmem_wdata = {2{StoreData_mem[15:0]}};
      if (!MemRead_mem) dmem_be = eff_lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load alignment and sign/zero extension
  always_comb begin
    sh = dmem_rdata >> {eff_lane, 3'b000};
    ld = dmem_rdata;
    if (is_byte)      ld = {{24{MemSigned_mem & sh[7]}},  sh[7:0]};
    else if (is_half) ld = {{16{MemSigned_mem & sh[15]}}, sh[15:0]};
  end

  // Handshake FSM next state, wait counter and request/abort decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        req = op & ~misal;
        if (req && !dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (to_hit) begin
          // Abort: drop req this cycle so a late ack is not sampled
          bus_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          req = 1'b1;
          if (dmem_ack) state_d = S_IDLE;
          else          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = req & ~dmem_ack;
  assign done  = req & dmem_ack;
  assign take  = ~stall & ~bus_err & ~misal;

  // Reset kills the request combinationally even if upstream still presents an op
  assign dmem_req  = req & ~rst;
  assign Stall_mem = stall & ~rst;

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: stalls, aborts and traps load a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MemToReg_q  <= 1'b0;
      RegWrite_q  <= 1'b0;
      WriteReg_q  <= '0;
      ALUResult_q <= '0;
      MemDout_q   <= '0;
      BusErr_q    <= 1'b0;
    end else begin
      MemToReg_q  <= take & MemToReg_mem;
      RegWrite_q  <= take & RegWrite_mem;
      WriteReg_q  <= WriteReg_mem;
      ALUResult_q <= ALUResult_mem;
      MemDout_q   <= (done & MemRead_mem) ? ld : 32'h0;
      BusErr_q    <= bus_err;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal_q;
  // One-cycle misalignment trap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misal_q <= 1'b0;
    else     misal_q <= misal;
  end
  assign Misalign_wb = misal_q;
`endif

  assign MemToReg_wb  = MemToReg_q;
  assign RegWrite_wb  = RegWrite_q;
  assign WriteReg_wb  = WriteReg_q;
  assign ALUResult_wb = ALUResult_q;
  assign MemDout_wb   = MemDout_q;
  assign BusErr_wb    = BusErr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT_CYC = 4).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_mem, MemWrite_mem, MemToReg_mem, RegWrite_mem;
  logic [1:0]  MemSize_mem;
  logic        MemSigned_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] ALUResult_mem, StoreData_mem;
  logic        Stall_mem, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        MemToReg_wb, RegWrite_wb, BusErr_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] MemDout_wb, ALUResult_wb;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        Misalign_wb;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .MemToReg_mem(MemToReg_mem), .RegWrite_mem(RegWrite_mem),
    .MemSize_mem(MemSize_mem), .MemSigned_mem(MemSigned_mem),
    .WriteReg_mem(WriteReg_mem), .ALUResult_mem(ALUResult_mem),
    .StoreData_mem(StoreData_mem), .Stall_mem(Stall_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack),
`ifdef MEM_MISALIGN_TRAP_EN
    .Misalign_wb(Misalign_wb),
`endif
    .MemToReg_wb(MemToReg_wb), .RegWrite_wb(RegWrite_wb),
    .WriteReg_wb(WriteReg_wb), .MemDout_wb(MemDout_wb),
    .ALUResult_wb(ALUResult_wb), .BusErr_wb(BusErr_wb)
  );

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] sd);
    MemRead_mem   = rd;
    MemWrite_mem  = wr;
    MemToReg_mem  = rd;
    RegWrite_mem  = rd;
    MemSize_mem   = sz;
    MemSigned_mem = sg;
    WriteReg_mem  = 5'd9;
    ALUResult_mem = addr;
    StoreData_mem = sd;
  endtask

  task automatic clr_op();
    set_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    WriteReg_mem = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_op(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", dmem_req); end
    checks++; if (Stall_mem !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", Stall_mem); end
    checks++; if ({MemToReg_wb, RegWrite_wb, BusErr_wb} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {MemToReg_wb, RegWrite_wb, BusErr_wb}); end
    checks++; if ({MemDout_wb, ALUResult_wb, WriteReg_wb} !== 69'h0) begin errors++; $display("FAIL rst_data got %h/%h/%h exp 0", MemDout_wb, ALUResult_wb, WriteReg_wb); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_nonmem();
    @(negedge clk);
    clr_op(); RegWrite_mem = 1'b1; ALUResult_mem = 32'h1234; WriteReg_mem = 5'd7;
    dmem_ack = 1'b1;  // stray ack in IDLE must be ignored
    #1;
    checks++; if ({dmem_req, Stall_mem} !== 2'b00) begin errors++; $display("FAIL nonmem_req got %b exp 00", {dmem_req, Stall_mem}); end
    @(posedge clk); #1;
    checks++; if (ALUResult_wb !== 32'h1234) begin errors++; $display("FAIL nonmem_alu got %h exp 00001234", ALUResult_wb); end
    checks++; if ({RegWrite_wb, MemToReg_wb, WriteReg_wb} !== {1'b1, 1'b0, 5'd7}) begin errors++; $display("FAIL nonmem_ctl got %b exp 1000111", {RegWrite_wb, MemToReg_wb, WriteReg_wb}); end
    checks++; if (MemDout_wb !== 32'h0) begin errors++; $display("FAIL nonmem_dout got %h exp 0", MemDout_wb); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
  endtask

  task automatic test_word_load();
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    dmem_rdata = 32'hDEADBEEF; dmem_ack = 1'b1;
    #1;
    checks++; if ({dmem_req, Stall_mem, dmem_we} !== 3'b100) begin errors++; $display("FAIL wl_req got %b exp 100", {dmem_req, Stall_mem, dmem_we}); end
    checks++; if ({dmem_addr, dmem_be} !== {32'h100, 4'hF}) begin errors++; $display("FAIL wl_addr got %h/%h exp 100/f", dmem_addr, dmem_be); end
    @(posedge clk); #1;
    checks++; if (MemDout_wb !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_dout got %h exp deadbeef", MemDout_wb); end
    checks++; if ({RegWrite_wb, MemToReg_wb, WriteReg_wb} !== {2'b11, 5'd9}) begin errors++; $display("FAIL wl_ctl got %b exp 1101001", {RegWrite_wb, MemToReg_wb, WriteReg_wb}); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
  endtask

  task automatic test_byte_load();
    int nst;
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
    dmem_rdata = 32'h80FF0011;
    nst = 0;
    // ack arrives in the third request cycle -> two stall cycles
    for (int c = 0; c < 8; c++) begin
      dmem_ack = (c == 2);
      #1;
      if (c == 1) begin
        checks++; if (RegWrite_wb !== 1'b0) begin errors++; $display("FAIL bl_bubble got %b exp 0", RegWrite_wb); end
      end
      if (!Stall_mem) break;
      nst++;
      @(negedge clk);
    end
    checks++; if (nst !== 2) begin errors++; $display("FAIL bl_stalls got %0d exp 2", nst); end
    @(posedge clk); #1;
    checks++; if (MemDout_wb !== 32'hFFFFFF80) begin errors++; $display("FAIL bl_signed got %h exp ffffff80", MemDout_wb); end
    checks++; if (RegWrite_wb !== 1'b1) begin errors++; $display("FAIL bl_rw got %b exp 1", RegWrite_wb); end
    @(negedge clk); MemSigned_mem = 1'b0; dmem_ack = 1'b1;
    #1;
    checks++; if (Stall_mem !== 1'b0) begin errors++; $display("FAIL blu_stall got %b exp 0", Stall_mem); end
    @(posedge clk); #1;
    checks++; if (MemDout_wb !== 32'h00000080) begin errors++; $display("FAIL bl_unsigned got %h exp 00000080", MemDout_wb); end
    // signed half from upper lane
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    dmem_rdata = 32'h80010000;
    @(posedge clk); #1;
    checks++; if (MemDout_wb !== 32'hFFFF8001) begin errors++; $display("FAIL hl_signed got %h exp ffff8001", MemDout_wb); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
  endtask

  task automatic test_store();
    @(negedge clk);
    set_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h1234ABCD); dmem_ack = 1'b1;
    #1;
    checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL hs_be got %b exp 1100", dmem_be); end
    checks++; if (dmem_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL hs_wdata got %h exp abcdabcd", dmem_wdata); end
    checks++; if ({dmem_addr, dmem_we, dmem_req} !== {32'h08, 2'b11}) begin errors++; $display("FAIL hs_addr got %h/%b/%b exp 8/1/1", dmem_addr, dmem_we, dmem_req); end
    @(negedge clk);
    set_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h01, 32'h00000055);
    #1;
    checks++; if ({dmem_be, dmem_wdata} !== {4'b0010, 32'h55555555}) begin errors++; $display("FAIL bs_lane got %b/%h exp 0010/55555555", dmem_be, dmem_wdata); end
    @(negedge clk);
    set_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFEF00D);
    #1;
    checks++; if ({dmem_be, dmem_wdata} !== {4'b1111, 32'hCAFEF00D}) begin errors++; $display("FAIL ws_lane got %b/%h exp 1111/cafef00d", dmem_be, dmem_wdata); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int nreq;
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0); dmem_ack = 1'b0;
    nreq = 0;
    // 1 issue cycle in IDLE + 4 WAIT cycles (counter 0..3); drops when counter hits 4
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!dmem_req) break;
      nreq++;
      @(negedge clk);
    end
    checks++; if (nreq !== 5) begin errors++; $display("FAIL to_reqcyc got %0d exp 5", nreq); end
    checks++; if (Stall_mem !== 1'b0) begin errors++; $display("FAIL to_stall got %b exp 0", Stall_mem); end
    @(posedge clk); #1;
    checks++; if ({BusErr_wb, RegWrite_wb, MemToReg_wb} !== 3'b100) begin errors++; $display("FAIL to_buserr got %b exp 100", {BusErr_wb, RegWrite_wb, MemToReg_wb}); end
    @(negedge clk); clr_op();
    @(posedge clk); #1;
    checks++; if (BusErr_wb !== 1'b0) begin errors++; $display("FAIL to_pulse got %b exp 0", BusErr_wb); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0); dmem_ack = 1'b0;
    @(negedge clk); #1;
    checks++; if (Stall_mem !== 1'b1) begin errors++; $display("FAIL rm_wait got %b exp 1", Stall_mem); end
    rst = 1'b1;
    #1;
    checks++; if ({dmem_req, Stall_mem} !== 2'b00) begin errors++; $display("FAIL rm_req got %b exp 00", {dmem_req, Stall_mem}); end
    checks++; if ({ALUResult_wb, WriteReg_wb, BusErr_wb} !== 38'h0) begin errors++; $display("FAIL rm_regs got %h/%h/%b exp 0", ALUResult_wb, WriteReg_wb, BusErr_wb); end
    clr_op();
    @(negedge clk); rst = 1'b0;
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    dmem_rdata = 32'h01020304; dmem_ack = 1'b1;
    #1;
    checks++; if ({dmem_req, Stall_mem} !== 2'b10) begin errors++; $display("FAIL rm_restart got %b exp 10", {dmem_req, Stall_mem}); end
    @(posedge clk); #1;
    checks++; if (MemDout_wb !== 32'h01020304) begin errors++; $display("FAIL rm_dout got %h exp 01020304", MemDout_wb); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    dmem_rdata = 32'h11223344; dmem_ack = 1'b1;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if ({dmem_req, Stall_mem} !== 2'b00) begin errors++; $display("FAIL ma_noreq got %b exp 00", {dmem_req, Stall_mem}); end
    @(posedge clk); #1;
    checks++; if ({Misalign_wb, RegWrite_wb} !== 2'b10) begin errors++; $display("FAIL ma_trap got %b exp 10", {Misalign_wb, RegWrite_wb}); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (Misalign_wb !== 1'b0) begin errors++; $display("FAIL ma_pulse got %b exp 0", Misalign_wb); end
`else
    checks++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h100, 4'hF}) begin errors++; $display("FAIL ma_addr got %b/%h/%b exp 1/100/1111", dmem_req, dmem_addr, dmem_be); end
    @(posedge clk); #1;
    checks++; if ({MemDout_wb, RegWrite_wb} !== {32'h11223344, 1'b1}) begin errors++; $display("FAIL ma_load got %h/%b exp 11223344/1", MemDout_wb, RegWrite_wb); end
    @(negedge clk); clr_op(); dmem_ack = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nonmem();
    test_word_load();
    test_byte_load();
    test_store();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
